bit_serial_core_p: RTL

Parametrised bit-serial CPU core, successor to the fixed 8-bit core. It has the following features:
- Configurable data width and register count.
- Accumulator architecture with serial ALU.
- Carry/zero flags, add-with-carry and compare.
- Valid/ready instruction handshake.
It sits between the instruction fetch/decode front end and the output latch/display logic.

---
 rtl/bsc_pkg.sv | 43 ++++
 rtl/bit_serial_core_p_alu_bit.sv | 63 ++++++
 rtl/bit_serial_core_p.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/bsc_pkg.sv
// rtl/bsc_pkg.sv - shared opcodes, FSM encoding and decode helpers for the bit-serial core
package bsc_pkg;

    localparam logic [3:0] OP_LDI  = 4'h0;
    localparam logic [3:0] OP_ADDI = 4'h1;
    localparam logic [3:0] OP_SUBI = 4'h2;
    localparam logic [3:0] OP_ANDI = 4'h3;
    localparam logic [3:0] OP_ORI  = 4'h4;
    localparam logic [3:0] OP_XORI = 4'h5;
    localparam logic [3:0] OP_ADDC = 4'h6;
    localparam logic [3:0] OP_CMPI = 4'h7;
    localparam logic [3:0] OP_LDR  = 4'h8;
    localparam logic [3:0] OP_ADD  = 4'h9;
    localparam logic [3:0] OP_SUB  = 4'hA;
    localparam logic [3:0] OP_AND  = 4'hB;
    localparam logic [3:0] OP_OR   = 4'hC;
    localparam logic [3:0] OP_XOR  = 4'hD;
    localparam logic [3:0] OP_STR  = 4'hE;
    localparam logic [3:0] OP_OUT  = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SERIAL = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // Ops that go through the bit-serial ALU; the rest finish in one COMMIT cycle.
    function automatic logic is_serial(input logic [3:0] op);
        return !(op == OP_LDI || op == OP_LDR || op == OP_STR || op == OP_OUT);
    endfunction

    // R-type ops take operand B from R[rs2] instead of imm.
    function automatic logic is_rtype(input logic [3:0] op);
        return op[3];
    endfunction

    // Arithmetic ops report the final carry; logic ops clear C.
    function automatic logic is_arith(input logic [3:0] op);
        return op == OP_ADDI || op == OP_SUBI || op == OP_ADDC || op == OP_CMPI ||
               op == OP_ADD  || op == OP_SUB;
    endfunction

endpackage

// File: rtl/bit_serial_core_p_alu_bit.sv
// rtl/bit_serial_core_p_alu_bit.sv - 1-bit serial ALU slice with registered carry
module bsc_alu_bit
    import bsc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a,
    input  logic       b,
    input  logic [2:0] op,
    input  logic       c_in,
    input  logic       start,
    input  logic       en,
    output logic       result,
    output logic       carry_out
);

    logic carry_q, carry_d;
    logic sub;
    logic b_eff;
    logic carry_init;

    // R-type ops share the low three opcode bits with their I-type twins,
    // so op[2:0] alone selects the function.
    assign sub   = (op == OP_SUBI[2:0]) || (op == OP_CMPI[2:0]);
    assign b_eff = b ^ sub;

    // Carry seed for the first bit, plus the carry chain across bits
    always_comb begin
        carry_init = 1'b0;
        if (sub) begin
            carry_init = 1'b1;
        end else if (op == OP_ADDC[2:0]) begin
            carry_init = c_in;
        end
        carry_d = carry_q;
        if (start) begin
            carry_d = carry_init;
        end else if (en) begin
            carry_d = carry_out;
        end
    end

    // Carry register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q <= 1'b0;
        end else begin
            carry_q <= carry_d;
        end
    end

    // Full-adder bit for arithmetic, plain gates for logic ops
    always_comb begin
        carry_out = (a & b_eff) | (a & carry_q) | (b_eff & carry_q);
        case (op)
            OP_ANDI[2:0]: result = a & b;
            OP_ORI[2:0]:  result = a | b;
            OP_XORI[2:0]: result = a ^ b;
            default:      result = a ^ b_eff ^ carry_q;
        endcase
    end

endmodule

// File: rtl/bit_serial_core_p.sv
// rtl/bit_serial_core_p.sv - parametrised accumulator CPU core with bit-serial ALU
module bit_serial_core_p
    import bsc_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 4,
    parameter int ZERO_R0  = 1,
    localparam int RA_W    = $clog2(NUM_REGS),
    localparam int INSTR_W = 4 + 2 * RA_W + DATA_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [INSTR_W-1:0] instr,
    output logic               done,
    output logic               busy,
    output logic [DATA_W-1:0]  out_result,
    output logic               out_valid,
    output logic               flag_z,
    output logic               flag_c,
    output logic [DATA_W-1:0]  acc_dbg
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    state_t             state_q, state_d;
    logic [3:0]         op_q, op_d;
    logic [RA_W-1:0]    rs1_q, rs1_d;
    logic [DATA_W-1:0]  a_q, a_d, b_q, b_d;
    logic [DATA_W-1:0]  shadow_q, shadow_d;
    logic [DATA_W-1:0]  acc_q, acc_d;
    logic [DATA_W-1:0]  out_result_q, out_result_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               flag_z_q, flag_z_d, flag_c_q, flag_c_d;
    logic               carry_fin_q, carry_fin_d;
    logic               out_valid_q, out_valid_d;
    logic [DATA_W-1:0]  regs_q [NUM_REGS];
    logic [DATA_W-1:0]  regs_d [NUM_REGS];

    logic [3:0]         in_op;
    logic [RA_W-1:0]    in_rs1, in_rs2;
    logic [DATA_W-1:0]  in_imm, rd1, rd2;
    logic               accept;
    logic [2:0]         alu_op;
    logic               alu_res, alu_cout;
    logic               r0_hit;

    assign in_op  = instr[INSTR_W-1 -: 4];
    assign in_rs1 = instr[INSTR_W-5 -: RA_W];
    assign in_rs2 = instr[DATA_W+RA_W-1 -: RA_W];
    assign in_imm = instr[DATA_W-1:0];
    assign accept = instr_valid && (state_q == ST_IDLE);

    // Register-file read ports, with R0 hardwired to zero when enabled
    always_comb begin
        rd1 = regs_q[in_rs1];
        rd2 = regs_q[in_rs2];
        if (ZERO_R0 != 0 && in_rs1 == '0) rd1 = '0;
        if (ZERO_R0 != 0 && in_rs2 == '0) rd2 = '0;
        r0_hit = (ZERO_R0 != 0) && (rs1_q == '0);
    end

    // The carry seed is loaded in the accept cycle, before op_q holds the new opcode
    assign alu_op = (state_q == ST_IDLE) ? in_op[2:0] : op_q[2:0];

    bsc_alu_bit u_alu (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a_q[0]),
        .b         (b_q[0]),
        .op        (alu_op),
        .c_in      (flag_c_q),
        .start     (accept),
        .en        (state_q == ST_SERIAL),
        .result    (alu_res),
        .carry_out (alu_cout)
    );

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept) state_d = is_serial(in_op) ? ST_SERIAL : ST_COMMIT;
            ST_SERIAL: if (cnt_q == LAST_BIT) state_d = ST_COMMIT;
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Datapath: operand snapshot, serial shifting and commit writes
    always_comb begin
        op_d         = op_q;
        rs1_d        = rs1_q;
        a_d          = a_q;
        b_d          = b_q;
        shadow_d     = shadow_q;
        acc_d        = acc_q;
        out_result_d = out_result_q;
        cnt_d        = cnt_q;
        flag_z_d     = flag_z_q;
        flag_c_d     = flag_c_q;
        carry_fin_d  = carry_fin_q;
        out_valid_d  = 1'b0;
        regs_d       = regs_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d  = in_op;
                    rs1_d = in_rs1;
                    a_d   = (in_op == OP_LDI) ? in_imm : rd1;
                    b_d   = is_rtype(in_op) ? rd2 : in_imm;
                    cnt_d = '0;
                end
            end
            ST_SERIAL: begin
                a_d         = a_q >> 1;
                b_d         = b_q >> 1;
                shadow_d    = {alu_res, shadow_q[DATA_W-1:1]};
                carry_fin_d = alu_cout;
                cnt_d       = cnt_q + 1'b1;
            end
            ST_COMMIT: begin
                case (op_q)
                    OP_LDI, OP_LDR: acc_d = a_q;
                    OP_STR: if (!r0_hit) regs_d[rs1_q] = acc_q;
                    OP_OUT: begin
                        out_result_d = acc_q;
                        out_valid_d  = 1'b1;
                    end
                    default: begin
                        if (op_q != OP_CMPI) acc_d = shadow_q;
                        flag_z_d = (shadow_q == '0);
                        flag_c_d = is_arith(op_q) ? carry_fin_q : 1'b0;
                    end
                endcase
            end
            default: ;
        endcase
    end

    // State and datapath registers; reset abandons any in-flight instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            op_q         <= '0;
            rs1_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            shadow_q     <= '0;
            acc_q        <= '0;
            out_result_q <= '0;
            cnt_q        <= '0;
            flag_z_q     <= 1'b0;
            flag_c_q     <= 1'b0;
            carry_fin_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            rs1_q        <= rs1_d;
            a_q          <= a_d;
            b_q          <= b_d;
            shadow_q     <= shadow_d;
            acc_q        <= acc_d;
            out_result_q <= out_result_d;
            cnt_q        <= cnt_d;
            flag_z_q     <= flag_z_d;
            flag_c_q     <= flag_c_d;
            carry_fin_q  <= carry_fin_d;
            out_valid_q  <= out_valid_d;
            regs_q       <= regs_d;
        end
    end

    // Status outputs decoded from the state register
    always_comb begin
        instr_ready = (state_q == ST_IDLE);
        busy        = (state_q != ST_IDLE);
        done        = (state_q == ST_COMMIT);
        out_result  = out_result_q;
        out_valid   = out_valid_q;
        flag_z      = flag_z_q;
        flag_c      = flag_c_q;
        acc_dbg     = acc_q;
    end

endmodule
